// File: rtl/uart_tx_fifo_if.sv
// Byte-write side of the UART transmitter: CPU write strobe/data in, free FIFO slots out.
interface uart_tx_fifo_if #(
    parameter int FIFO_DEPTH = 16
);
    logic                        wr_valid;
    logic [7:0]                  wr_data;
    logic [$clog2(FIFO_DEPTH):0] free_slots;

    modport master (output wr_valid, output wr_data, input free_slots);
    modport slave  (input wr_valid, input wr_data, output free_slots);
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an LSB-first 8N1 serialiser (8E1 when UART_TX_PARITY_EN is defined).
// Latency: byte written at edge E drives the start bit from E+1 when idle; frames run back to back.
// Backpressure: none; writes to a full FIFO are dropped unless a pop happens on the same edge.
module uart_tx_fifo #(
    parameter int CLOCKS_PER_BIT = 434,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic          clock,
    input  logic          reset,
    uart_tx_fifo_if.slave wr,
    output logic          tx_busy,
    output logic          UART_TX
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLOCKS_PER_BIT + 1);
    localparam logic [BW-1:0] BAUD_LOAD = BW'(CLOCKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, count_nxt;
    state_t        state, state_nxt;
    logic [BW-1:0] baud, baud_nxt;
    logic [2:0]    bit_idx, bit_idx_nxt;
    logic [7:0]    shift, shift_nxt;
    logic          tx_nxt;
    logic          push, pop;
    logic [7:0]    head;

    assign head = mem[rd_ptr];

    // A pop on the same edge frees a slot, so a write into a full FIFO still lands.
    always_comb begin
        push      = wr.wr_valid && ((count != DEPTH_C) || pop);
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_comb begin
        state_nxt   = state;
        baud_nxt    = baud;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        tx_nxt      = UART_TX;
        pop         = 1'b0;
        case (state)
            IDLE: begin
                tx_nxt = 1'b1;
                if (count != '0) begin
                    pop       = 1'b1;
                    shift_nxt = head;
                    tx_nxt    = 1'b0;
                    baud_nxt  = BAUD_LOAD;
                    state_nxt = START;
                end
            end
            START: begin
                if (baud == '0) begin
                    state_nxt   = DATA;
                    bit_idx_nxt = 3'd0;
                    baud_nxt    = BAUD_LOAD;
                    tx_nxt      = shift[0];
                end else begin
                    baud_nxt = baud - BW'(1);
                end
            end
            DATA: begin
                if (baud == '0) begin
                    baud_nxt = BAUD_LOAD;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt = PARITY;
                        tx_nxt    = ^shift;
`else
                        state_nxt = STOP;
                        tx_nxt    = 1'b1;
`endif
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                        tx_nxt      = shift[bit_idx + 3'd1];
                    end
                end else begin
                    baud_nxt = baud - BW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud == '0) begin
                    state_nxt = STOP;
                    baud_nxt  = BAUD_LOAD;
                    tx_nxt    = 1'b1;
                end else begin
                    baud_nxt = baud - BW'(1);
                end
            end
`endif
            STOP: begin
                // Chain straight into the next start bit so a stream has no idle gap.
                if (baud == '0) begin
                    if (count != '0) begin
                        pop       = 1'b1;
                        shift_nxt = head;
                        tx_nxt    = 1'b0;
                        baud_nxt  = BAUD_LOAD;
                        state_nxt = START;
                    end else begin
                        tx_nxt    = 1'b1;
                        state_nxt = IDLE;
                    end
                end else begin
                    baud_nxt = baud - BW'(1);
                end
            end
            default: begin
                tx_nxt    = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            baud          <= '0;
            bit_idx       <= '0;
            shift         <= '0;
            UART_TX       <= 1'b1;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            wr.free_slots <= DEPTH_C;
            tx_busy       <= 1'b0;
        end else begin
            state         <= state_nxt;
            baud          <= baud_nxt;
            bit_idx       <= bit_idx_nxt;
            shift         <= shift_nxt;
            UART_TX       <= tx_nxt;
            count         <= count_nxt;
            wr.free_slots <= DEPTH_C - count_nxt;
            tx_busy       <= (state_nxt != IDLE) || (count_nxt != '0);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= wr.wr_data;
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo at CLOCKS_PER_BIT=4: per-cycle frame vectors plus a serial-line scoreboard.
module tb_uart_tx_fifo;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = CPB * NB;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic tx_busy;
    logic UART_TX;

    uart_tx_fifo_if #(.FIFO_DEPTH(16)) wr_if ();

    uart_tx_fifo #(.CLOCKS_PER_BIT(CPB), .FIFO_DEPTH(16)) dut (
        .clock   (clock),
        .reset   (reset),
        .wr      (wr_if),
        .tx_busy (tx_busy),
        .UART_TX (UART_TX)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [7:0] sb[$];
    int         start_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Serial-line receiver: samples mid-bit and checks against the scoreboard.
    bit         m_active = 1'b0;
    int         m_t      = 0;
    logic [7:0] m_byte   = 8'h00;
    logic       m_par    = 1'b0;
    logic [7:0] m_exp;
    always @(negedge clock) begin
        cyc = cyc + 1;
        if (reset) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (UART_TX === 1'b0) begin
                m_active = 1'b1;
                m_t      = 0;
                m_byte   = 8'h00;
                start_q.push_back(cyc);
            end
        end else begin
            m_t = m_t + 1;
            if (m_t % CPB == CPB / 2) begin
                if (m_t / CPB == 0) begin
                    chk("mon_start_bit", 32'(UART_TX), 32'd0);
                end else if (m_t / CPB <= 8) begin
                    m_byte[m_t / CPB - 1] = UART_TX;
                end else if (m_t / CPB < NB - 1) begin
                    m_par = UART_TX;
                end else begin
                    chk("mon_stop_bit", 32'(UART_TX), 32'd1);
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL mon_unexpected_frame: got byte %0h, expected no frame", m_byte);
                    end else begin
                        m_exp = sb.pop_front();
                        chk("mon_byte", 32'(m_byte), 32'(m_exp));
`ifdef UART_TX_PARITY_EN
                        chk("mon_parity", 32'(m_par), 32'(^m_exp));
`endif
                    end
                    m_active = 1'b0;
                end
            end
        end
    end

    task automatic drive(input logic [7:0] d);
        @(posedge clock);
        #1;
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = d;
    endtask

    task automatic idle();
        @(posedge clock);
        #1;
        wr_if.wr_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int max_cyc);
        bit done = 1'b0;
        for (int i = 0; i < max_cyc && !done; i++) begin
            @(negedge clock);
            if (!tx_busy && sb.size() == 0 && !m_active) done = 1'b1;
        end
        chk(name, 32'(done), 32'd1);
    endtask

    // Expected line level k cycles after the write edge.
    function automatic logic exp_line(input int k, input logic [7:0] d, input logic p);
        int idx;
        if (k < 1) return 1'b1;
        idx = (k - 1) / CPB;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == 9) return p;
`else
        if (idx == 9) return 1'b1 | p;
`endif
        return 1'b1;
    endfunction

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic [4:0] free_after_push;
    } vec_t;
    vec_t vecs[7];

    initial begin
        int n0;
        vecs[0] = '{8'hA5, 1'b0, 5'd15};
        vecs[1] = '{8'h07, 1'b1, 5'd15};
        vecs[2] = '{8'h03, 1'b0, 5'd15};
        vecs[3] = '{8'h00, 1'b0, 5'd15};
        vecs[4] = '{8'hFF, 1'b0, 5'd15};
        vecs[5] = '{8'h80, 1'b1, 5'd15};
        vecs[6] = '{8'h01, 1'b1, 5'd15};

        // Reset held with a write pending: nothing is queued.
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = 8'hC3;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_free_slots", 32'(wr_if.free_slots), 32'd16);
        chk("rst_tx_busy", 32'(tx_busy), 32'd0);
        chk("rst_uart_tx", 32'(UART_TX), 32'd1);
        @(posedge clock);
        #1;
        reset          = 1'b0;
        wr_if.wr_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            chk("post_rst_uart_tx", 32'(UART_TX), 32'd1);
            chk("post_rst_tx_busy", 32'(tx_busy), 32'd0);
        end

        // Single-byte frames checked cycle by cycle from the write edge.
        for (int v = 0; v < 7; v++) begin
            sb.push_back(vecs[v].data);
            drive(vecs[v].data);
            idle();
            for (int k = 0; k <= FRAME + 1; k++) begin
                @(negedge clock);
                chk($sformatf("vec%0d_line_k%0d", v, k), 32'(UART_TX),
                    32'(exp_line(k, vecs[v].data, vecs[v].par)));
                chk($sformatf("vec%0d_busy_k%0d", v, k), 32'(tx_busy), (k <= FRAME) ? 32'd1 : 32'd0);
                if (k == 0) chk($sformatf("vec%0d_free_push", v), 32'(wr_if.free_slots),
                                32'(vecs[v].free_after_push));
                if (k == 1) chk($sformatf("vec%0d_free_pop", v), 32'(wr_if.free_slots), 32'd16);
            end
        end
        drain("drain_vectors", 50);

        // Back-to-back frames with no idle gap.
        start_q.delete();
        sb.push_back(8'h00);
        sb.push_back(8'hFF);
        sb.push_back(8'h55);
        drive(8'h00);
        drive(8'hFF);
        drive(8'h55);
        idle();
        drain("drain_b2b", 4 * FRAME);
        chk("b2b_frames", 32'(start_q.size()), 32'd3);
        if (start_q.size() >= 3) begin
            chk("b2b_gap1", 32'(start_q[1] - start_q[0]), 32'(FRAME));
            chk("b2b_gap2", 32'(start_q[2] - start_q[1]), 32'(FRAME));
        end

        // Overflow: 20 writes, the first is popped immediately, 0x11..0x13 dropped.
        for (int i = 0; i < 20; i++) begin
            if (i <= 16) sb.push_back(8'(i));
            drive(8'(i));
        end
        idle();
        @(negedge clock);
        chk("ovf_free_zero", 32'(wr_if.free_slots), 32'd0);
        chk("ovf_busy", 32'(tx_busy), 32'd1);
        drain("drain_overflow", 18 * FRAME + 50);
        chk("ovf_free_after", 32'(wr_if.free_slots), 32'd16);

        // Full FIFO: write lands on the STOP-to-START pop edge.
        for (int i = 0; i <= 16; i++) begin
            sb.push_back(8'(8'h20 + i));
            drive(8'(8'h20 + i));
        end
        idle();
        sb.push_back(8'h77);
        repeat (FRAME - 17) idle();
        drive(8'h77);
        @(negedge clock);
        chk("full_free_before", 32'(wr_if.free_slots), 32'd0);
        idle();
        @(negedge clock);
        chk("full_free_after", 32'(wr_if.free_slots), 32'd0);
        chk("full_next_start", 32'(UART_TX), 32'd0);
        drain("drain_full", 19 * FRAME + 50);

        // Reset during data bit 3 with five bytes queued.
        for (int i = 0; i < 6; i++) drive(8'(8'h40 + i));
        idle();
        repeat (12) idle();
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("midrst_uart_tx", 32'(UART_TX), 32'd1);
        chk("midrst_free", 32'(wr_if.free_slots), 32'd16);
        chk("midrst_busy", 32'(tx_busy), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        n0 = start_q.size();
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            chk("midrst_line_idle", 32'(UART_TX), 32'd1);
        end
        chk("midrst_no_frames", 32'(start_q.size()), 32'(n0));
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Transmit side of the UART behind the UART_TX hardware register at E0000010.
- hwregs forwards CPU writes as single bytes, which are queued in a FIFO and serialised onto the UART_TX pin as 8N1 frames, LSB first.
- hwregs reads free_slots as the value returned for reads of E0000010, zero-extended to 32 bits.

Parameters:
- CLOCKS_PER_BIT, 434, clock cycles per bit period (50 MHz / 115200). Legal range 2..65535.
- FIFO_DEPTH, 16, number of byte entries. Must be a power of 2, minimum 2.

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- wr_valid  in  1  one-cycle strobe: push wr_data (CPU write to E0000010)
- wr_data  in  8  byte to transmit (cpud_wdata[7:0])
- free_slots  out  $clog2(FIFO_DEPTH)+1  empty FIFO entries, range 0..FIFO_DEPTH
- tx_busy  out  1  high while a frame is on the wire or the FIFO is non-empty
- UART_TX  out  1  serial line; idle high

Behaviour:
- Reset is synchronous and active-high on clock.
  - The FIFO is emptied.
  - free_slots = FIFO_DEPTH, tx_busy = 0, UART_TX = 1.
  - The FSM goes to IDLE and the bit counter and baud counter are cleared.
- Reset asserted mid-frame aborts the frame. UART_TX is 1 on the cycle after the reset edge and all queued bytes are discarded.
- FIFO:
  - Circular buffer with read and write pointers and a count register.
  - free_slots = FIFO_DEPTH - count, registered, and updated on the same edge as the push or pop.
- Push:
  - wr_valid with count < FIFO_DEPTH stores the byte.
  - wr_valid with count == FIFO_DEPTH drops the byte silently; the FIFO contents and count are unchanged.
- Pop: performed by the FSM only, and only when count > 0.
- Simultaneous push and pop:
  - Both occur and count is unchanged.
  - When the FIFO is full, the push still succeeds because the pop frees a slot on the same edge; count stays at FIFO_DEPTH.
- Pointers wrap modulo FIFO_DEPTH.
- FSM states:
  - IDLE: UART_TX = 1. If count > 0, pop the head byte into the shift register, drive UART_TX = 0, load the baud counter and go to START.
  - START: hold UART_TX = 0 for CLOCKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: drive shift[bit index] for CLOCKS_PER_BIT cycles per bit, for bits 0..7, then go to STOP.
  - STOP: drive UART_TX = 1 for CLOCKS_PER_BIT cycles.
    - At the end, if count > 0, pop the next byte and enter START on the same edge, so there are no idle cycles between frames.
    - Otherwise go to IDLE.
- Timing:
  - A write sampled at edge E into an empty FIFO with the FSM in IDLE gives UART_TX low from edge E+1.
  - Each bit lasts exactly CLOCKS_PER_BIT cycles. A frame is exactly 10*CLOCKS_PER_BIT cycles.
  - A back-to-back stream produces one frame per 10*CLOCKS_PER_BIT cycles.
- Baud counter: counts down from CLOCKS_PER_BIT-1 to 0; the bit advances at 0. Width is $clog2(CLOCKS_PER_BIT+1).
- UART_TX is driven from a flop (glitch-free).
- tx_busy = (state != IDLE) || (count != 0), registered.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP.
  - It drives the even-parity bit (XOR of the 8 data bits) for CLOCKS_PER_BIT cycles.
  - A frame is 11*CLOCKS_PER_BIT cycles (8E1).
- When undefined: no parity logic is present and frames are 8N1 at 10*CLOCKS_PER_BIT cycles.
- Ports and FIFO behaviour are identical in both builds.

Test Plan:
- Reset: hold reset for 3 cycles with wr_valid=1 -> free_slots=16, tx_busy=0, UART_TX=1, no frame starts after release.
- Single byte: CLOCKS_PER_BIT=4, write 0xA5 at edge E -> UART_TX low from E+1 for 4 cycles.
  - Data bits 1,0,1,0,0,1,0,1, 4 cycles each, then high for 4 cycles.
  - tx_busy drops at E+41; free_slots goes 16->15->16.
- Back-to-back: write 0x00, 0xFF, 0x55 on consecutive cycles -> three frames with no idle gap; the second start bit begins exactly 40 cycles after the first.
- Overflow:
  - Write 20 bytes 0x00..0x13 on consecutive cycles while the first is transmitting -> free_slots reaches 0.
  - The bytes transmitted are the 17 bytes 0x00..0x10, and 0x11..0x13 are dropped, because 0x00 was popped one cycle after its push and freed a slot.
- Full FIFO with push and pop on the same cycle: with count=16, write 0x77 on the STOP-to-START pop edge -> free_slots stays 0 and 0x77 is transmitted last.
- Reset mid-frame: assert reset during DATA bit 3 with 5 bytes queued -> UART_TX=1 the next cycle, free_slots=16, and no further frames are sent.
- Parity (with UART_TX_PARITY_EN): send 0x07 -> parity bit 1, frame 44 cycles at CLOCKS_PER_BIT=4. Send 0x03 -> parity bit 0.
